// File: rtl/lcd_bus_pkg.sv
// Shared constants, FSM state type and DDRAM address helpers for the LCD bus monitor.
package lcd_bus_pkg;

    // HD44780 command bytes recognised by the monitor
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_ENTRY     = 8'h04;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    // 2x16 display layout
    localparam logic [6:0] ROW1_BASE  = 7'h40;
    localparam int         LCD_COLS   = 16;
    localparam int         LCD_CELLS  = 32;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } lcd_state_t;

    // Visible DDRAM is 0x00-0x0F and 0x40-0x4F: both have AC[5:4] == 0.
    function automatic logic ac_visible(input logic [6:0] ac);
        return (ac[5:4] == 2'b00);
    endfunction

    // Shadow cell index {row, col} for a visible AC value.
    function automatic logic [4:0] ac_to_cell(input logic [6:0] ac);
        return {ac[6], ac[3:0]};
    endfunction

endpackage

// File: rtl/lcd_bus_monitor_sync.sv
// Bus input synchronizer, lcd_en falling-edge detector and enable high-width measurement.
module lcd_bus_sync #(
    parameter int MIN_EN_HIGH = 4
) (
    input  logic       clk_1MHz,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data,
    output logic       txn,
    output logic       txn_short,
    output logic       rs,
    output logic       rw,
    output logic [7:0] data
);

    localparam int CW = $clog2(MIN_EN_HIGH + 1);

    // Packed bus word: {en, rs, rw, data[7:0]}
    logic [10:0]   meta_reg;
    logic [10:0]   sync_reg;
    logic          en_prev_reg;
    logic [CW-1:0] width_reg;
    logic          en_sync;

    assign en_sync = sync_reg[10];

    // Two-flop synchronizer; reset to en = 0 so no false falling edge follows reset.
    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            meta_reg    <= '0;
            sync_reg    <= '0;
            en_prev_reg <= 1'b0;
        end else begin
            meta_reg    <= {lcd_en, lcd_rs, lcd_rw, lcd_data};
            sync_reg    <= meta_reg;
            en_prev_reg <= en_sync;
        end
    end

    // Count cycles of synchronized en high, saturating at the minimum legal width.
    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            width_reg <= '0;
        end else if (!en_sync) begin
            width_reg <= '0;
        end else if (width_reg != CW'(MIN_EN_HIGH)) begin
            width_reg <= width_reg + CW'(1);
        end
    end

    // The fall cycle still sees the completed high-width count and the bus values of that stage.
    assign txn       = en_prev_reg & ~en_sync;
    assign txn_short = (width_reg < CW'(MIN_EN_HIGH));
    assign rs        = sync_reg[9];
    assign rw        = sync_reg[8];
    assign data      = sync_reg[7:0];

endmodule

// File: rtl/lcd_bus_monitor.sv
// Character-LCD bus monitor: decodes command/data writes, mirrors visible DDRAM, flags violations.
module lcd_bus_monitor
    import lcd_bus_pkg::*;
#(
    parameter int MIN_EN_HIGH  = 4,
    parameter int CLEAR_CYCLES = 32   // must cover all LCD_CELLS, one cell per cycle
) (
    input  logic       clk_1MHz,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] cursor,
    output logic       busy,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       wr_valid,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_char,
    output logic       frame_done,
    output logic       err_short_en,
    output logic       err_rw,
    output logic       err_addr,
    output logic       err_busy,
    input  logic       clear_err
);

    localparam int         IW      = $clog2(CLEAR_CYCLES);
    localparam logic [6:0] LAST_AC = ROW1_BASE + 7'(LCD_COLS - 1);

    logic       txn, txn_short, txn_rs, txn_rw;
    logic [7:0] txn_data;

    lcd_bus_sync #(
        .MIN_EN_HIGH(MIN_EN_HIGH)
    ) u_sync (
        .clk_1MHz (clk_1MHz),
        .rst      (rst),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .lcd_data (lcd_data),
        .txn      (txn),
        .txn_short(txn_short),
        .rs       (txn_rs),
        .rw       (txn_rw),
        .data     (txn_data)
    );

    lcd_state_t state_reg, state_next;
    logic [6:0]    cursor_reg, cursor_next;
    logic          inc_reg, inc_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic          cmd_valid_reg, cmd_valid_next;
    logic [7:0]    cmd_byte_reg, cmd_byte_next;
    logic          wr_valid_reg, wr_valid_next;
    logic [4:0]    wr_addr_reg, wr_addr_next;
    logic [7:0]    wr_char_reg, wr_char_next;
    logic          frame_done_reg, frame_done_next;
    logic          err_short_reg, err_rw_reg, err_addr_reg, err_busy_reg;
    logic          set_short, set_rw, set_addr, set_busy;

    // Single shadow write port shared by the clear sweep and data writes (never both at once).
    logic          cell_we;
    logic [4:0]    cell_addr;
    logic [7:0]    cell_data;
    logic [7:0]    cells [LCD_CELLS];
    logic [7:0]    rd_char_reg;

    // FSM state register
    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, transaction decode and shadow write selection
    always_comb begin
        state_next      = state_reg;
        cursor_next     = cursor_reg;
        inc_next        = inc_reg;
        idx_next        = idx_reg;
        cmd_valid_next  = 1'b0;
        cmd_byte_next   = cmd_byte_reg;
        wr_valid_next   = 1'b0;
        wr_addr_next    = wr_addr_reg;
        wr_char_next    = wr_char_reg;
        frame_done_next = 1'b0;
        set_short       = 1'b0;
        set_rw          = 1'b0;
        set_addr        = 1'b0;
        set_busy        = 1'b0;
        cell_we         = 1'b0;
        cell_addr       = '0;
        cell_data       = CHAR_SPACE;

        if (state_reg == ST_CLEAR) begin
            if (int'(idx_reg) < LCD_CELLS) begin
                cell_we   = 1'b1;
                cell_addr = idx_reg[4:0];
            end
            if (idx_reg == IW'(CLEAR_CYCLES - 1)) begin
                state_next = ST_IDLE;
                idx_next   = '0;
            end else begin
                idx_next = idx_reg + IW'(1);
            end
        end

        if (txn) begin
            if (txn_short) begin
                set_short = 1'b1;
            end else if (state_reg == ST_CLEAR) begin
                set_busy = 1'b1;
            end else if (txn_rw) begin
                set_rw = 1'b1;
            end else if (!txn_rs) begin
                cmd_valid_next = 1'b1;
                cmd_byte_next  = txn_data;
                casez (txn_data)
                    8'b1???_????: cursor_next = txn_data[6:0];
                    8'b0000_0001: begin
                        cursor_next = '0;
                        inc_next    = 1'b1;
                        state_next  = ST_CLEAR;
                        idx_next    = '0;
                    end
                    8'b0000_001?: cursor_next = '0;
                    8'b0000_01??: inc_next = txn_data[1];
                    default: ;
                endcase
            end else begin
                if (ac_visible(cursor_reg)) begin
                    cell_we         = 1'b1;
                    cell_addr       = ac_to_cell(cursor_reg);
                    cell_data       = txn_data;
                    wr_valid_next   = 1'b1;
                    wr_addr_next    = ac_to_cell(cursor_reg);
                    wr_char_next    = txn_data;
                    frame_done_next = (cursor_reg == LAST_AC);
                end else begin
                    set_addr = 1'b1;
                end
                cursor_next = inc_reg ? cursor_reg + 7'd1 : cursor_reg - 7'd1;
            end
        end
    end

    // Datapath registers: address counter, report outputs and sticky errors
    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            cursor_reg     <= '0;
            inc_reg        <= 1'b1;
            idx_reg        <= '0;
            cmd_valid_reg  <= 1'b0;
            cmd_byte_reg   <= '0;
            wr_valid_reg   <= 1'b0;
            wr_addr_reg    <= '0;
            wr_char_reg    <= '0;
            frame_done_reg <= 1'b0;
            err_short_reg  <= 1'b0;
            err_rw_reg     <= 1'b0;
            err_addr_reg   <= 1'b0;
            err_busy_reg   <= 1'b0;
        end else begin
            cursor_reg     <= cursor_next;
            inc_reg        <= inc_next;
            idx_reg        <= idx_next;
            cmd_valid_reg  <= cmd_valid_next;
            cmd_byte_reg   <= cmd_byte_next;
            wr_valid_reg   <= wr_valid_next;
            wr_addr_reg    <= wr_addr_next;
            wr_char_reg    <= wr_char_next;
            frame_done_reg <= frame_done_next;
            // a new error wins over a simultaneous clear
            err_short_reg  <= (err_short_reg & ~clear_err) | set_short;
            err_rw_reg     <= (err_rw_reg    & ~clear_err) | set_rw;
            err_addr_reg   <= (err_addr_reg  & ~clear_err) | set_addr;
            err_busy_reg   <= (err_busy_reg  & ~clear_err) | set_busy;
        end
    end

    // Shadow DDRAM: reset straight to blanks, one write per cycle
    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LCD_CELLS; i++) begin
                cells[i] <= CHAR_SPACE;
            end
        end else if (cell_we) begin
            for (int i = 0; i < LCD_CELLS; i++) begin
                if (cell_addr == 5'(i)) begin
                    cells[i] <= cell_data;
                end
            end
        end
    end

    // Registered shadow read; a same-cycle write to the cell returns the old value
    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            rd_char_reg <= '0;
        end else begin
            rd_char_reg <= cells[rd_addr];
        end
    end

    assign rd_char      = rd_char_reg;
    assign cursor       = cursor_reg;
    assign busy         = (state_reg == ST_CLEAR);
    assign cmd_valid    = cmd_valid_reg;
    assign cmd_byte     = cmd_byte_reg;
    assign wr_valid     = wr_valid_reg;
    assign wr_addr      = wr_addr_reg;
    assign wr_char      = wr_char_reg;
    assign frame_done   = frame_done_reg;
    assign err_short_en = err_short_reg;
    assign err_rw       = err_rw_reg;
    assign err_addr     = err_addr_reg;
    assign err_busy     = err_busy_reg;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Scoreboard bench for lcd_bus_monitor: stimulus queues expected reports, a monitor checks them.
module tb_lcd_bus_monitor;

    logic       clk_1MHz = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0, clear_err = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic [4:0] rd_addr = 5'h00;
    logic [7:0] rd_char, cmd_byte, wr_char;
    logic [6:0] cursor;
    logic [4:0] wr_addr;
    logic       busy, cmd_valid, wr_valid, frame_done;
    logic       err_short_en, err_rw, err_addr, err_busy;

    lcd_bus_monitor #(
        .MIN_EN_HIGH (4),
        .CLEAR_CYCLES(32)
    ) dut (
        .clk_1MHz    (clk_1MHz),
        .rst         (rst),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_en      (lcd_en),
        .lcd_data    (lcd_data),
        .rd_addr     (rd_addr),
        .rd_char     (rd_char),
        .cursor      (cursor),
        .busy        (busy),
        .cmd_valid   (cmd_valid),
        .cmd_byte    (cmd_byte),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_char     (wr_char),
        .frame_done  (frame_done),
        .err_short_en(err_short_en),
        .err_rw      (err_rw),
        .err_addr    (err_addr),
        .err_busy    (err_busy),
        .clear_err   (clear_err)
    );

    always #5 clk_1MHz = ~clk_1MHz;

    typedef struct {
        bit         is_cmd;
        logic [7:0] b;
        logic [4:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0, n_fail = 0;
    int   cyc = 0, fall_cyc = 0;
    int   frame_cnt = 0, busy_cnt = 0;

    always @(posedge clk_1MHz) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: pops one expected report per cmd_valid / wr_valid pulse
    exp_t e;
    always @(negedge clk_1MHz) begin
        if (busy) busy_cnt++;
        if (frame_done) frame_cnt++;
        if (cmd_valid || wr_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_report: got cmd_valid=%0b wr_valid=%0b, required none",
                         cmd_valid, wr_valid);
            end else begin
                e = exp_q.pop_front();
                check("report_kind", 32'(cmd_valid), 32'(e.is_cmd));
                check("report_latency", 32'(cyc - fall_cyc), 32'd3);
                if (e.is_cmd) begin
                    check("cmd_byte", 32'(cmd_byte), 32'(e.b));
                    if (e.b == 8'h01) check("busy_with_clear_cmd", 32'(busy), 32'd1);
                end else begin
                    check("wr_addr", 32'(wr_addr), 32'(e.addr));
                    check("wr_char", 32'(wr_char), 32'(e.b));
                end
            end
        end
    end

    task automatic bus(input logic rs, input logic rw, input logic [7:0] d, input int hi);
        @(negedge clk_1MHz);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
        repeat (hi) @(negedge clk_1MHz);
        lcd_en   = 1'b0;
        fall_cyc = cyc;
        $display("txn rs=%0b rw=%0b data=%02h en_high=%0d", rs, rw, d, hi);
        repeat (6) @(negedge clk_1MHz);
    endtask

    task automatic send_cmd(input logic [7:0] b, input int hi);
        exp_t x;
        x.is_cmd = 1'b1; x.b = b; x.addr = 5'h00;
        exp_q.push_back(x);
        bus(1'b0, 1'b0, b, hi);
    endtask

    task automatic send_data(input logic [7:0] d, input logic [4:0] a, input int hi);
        exp_t x;
        x.is_cmd = 1'b0; x.b = d; x.addr = a;
        exp_q.push_back(x);
        bus(1'b1, 1'b0, d, hi);
    endtask

    task automatic read_cell(input logic [4:0] a, output logic [7:0] v);
        @(negedge clk_1MHz);
        rd_addr = a;
        @(negedge clk_1MHz);
        v = rd_char;
    endtask

    task automatic pulse_clear_err();
        @(negedge clk_1MHz);
        clear_err = 1'b1;
        @(negedge clk_1MHz);
        clear_err = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    string      row0 = "GAMEOVER        ";
    string      row1 = "SCORE:00001234  ";
    logic [7:0] v, ch;
    logic [6:0] ac;

    initial begin
        // Reset state
        repeat (3) @(negedge clk_1MHz);
        check("reset_rd_char", 32'(rd_char), 32'h00);
        check("reset_cursor", 32'(cursor), 32'h00);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_errors", 32'({err_short_en, err_rw, err_addr, err_busy}), 32'h0);
        check("reset_pulses", 32'({cmd_valid, wr_valid, frame_done}), 32'h0);
        check("reset_held", 32'({cmd_byte, wr_addr, wr_char}), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_cell(5'(i), v);
            check("reset_cell", 32'(v), 32'h20);
        end

        // Set address 0x04, write 'G'(0x47), long enable pulses
        send_cmd(8'h84, 500);
        send_data(8'h47, 5'h04, 500);
        check("cursor_after_47", 32'(cursor), 32'h05);
        read_cell(5'h04, v);
        check("cell4_47", 32'(v), 32'h47);

        // Full two-row frame as set-address/data pairs
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 16; c++) begin
                ac = (r == 1) ? 7'(8'h40 + c) : 7'(c);
                ch = (r == 1) ? row1[c] : row0[c];
                send_cmd({1'b1, ac}, 6);
                send_data(ch, {r[0], 4'(c)}, 6);
            end
        end
        check("frame_done_count", 32'(frame_cnt), 32'd1);
        check("frame_reports_drained", 32'(exp_q.size()), 32'd0);
        check("frame_errors", 32'({err_short_en, err_rw, err_addr, err_busy}), 32'h0);
        check("frame_cursor", 32'(cursor), 32'h50);
        for (int i = 0; i < 32; i++) begin
            read_cell(5'(i), v);
            ch = (i >= 16) ? row1[i - 16] : row0[i];
            check("frame_cell", 32'(v), 32'(ch));
        end

        // One-cycle enable is too short: dropped
        bus(1'b1, 1'b0, 8'h58, 1);
        check("short_err", 32'(err_short_en), 32'd1);
        check("short_no_addr_err", 32'(err_addr), 32'd0);
        check("short_cursor", 32'(cursor), 32'h50);
        pulse_clear_err();
        check("short_cleared", 32'(err_short_en), 32'd0);

        // Clear command, then a data transaction falling 10 cycles after it
        busy_cnt = 0;
        begin
            exp_t x;
            x.is_cmd = 1'b1; x.b = 8'h01; x.addr = 5'h00;
            exp_q.push_back(x);
        end
        @(negedge clk_1MHz);
        lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h01; lcd_en = 1'b1;
        repeat (6) @(negedge clk_1MHz);
        lcd_en   = 1'b0;
        fall_cyc = cyc;
        $display("txn rs=0 rw=0 data=01 en_high=6");
        repeat (2) @(negedge clk_1MHz);
        lcd_rs = 1'b1; lcd_data = 8'h33; lcd_en = 1'b1;
        repeat (8) @(negedge clk_1MHz);
        lcd_en = 1'b0;
        $display("txn rs=1 rw=0 data=33 en_high=8 (during clear)");
        repeat (50) @(negedge clk_1MHz);
        check("clear_busy_cycles", 32'(busy_cnt), 32'd32);
        check("clear_err_busy", 32'(err_busy), 32'd1);
        check("clear_cursor", 32'(cursor), 32'h00);
        check("clear_busy_done", 32'(busy), 32'd0);
        for (int i = 0; i < 32; i++) begin
            read_cell(5'(i), v);
            check("clear_cell", 32'(v), 32'h20);
        end
        pulse_clear_err();
        check("busy_err_cleared", 32'(err_busy), 32'd0);

        // Invisible address, decrement mode, wrap and read-cycle violation
        send_cmd(8'hA0, 6);
        bus(1'b1, 1'b0, 8'h55, 6);
        check("addr_err", 32'(err_addr), 32'd1);
        check("addr_cursor", 32'(cursor), 32'h21);
        send_cmd(8'h04, 6);
        send_cmd(8'h80, 6);
        send_data(8'h41, 5'h00, 6);
        check("dec_cursor_wrap", 32'(cursor), 32'h7F);
        read_cell(5'h00, v);
        check("cell0_41", 32'(v), 32'h41);
        bus(1'b0, 1'b1, 8'h80, 6);
        check("rw_err", 32'(err_rw), 32'd1);
        check("rw_cursor", 32'(cursor), 32'h7F);
        check("addr_err_sticky", 32'(err_addr), 32'd1);

        // Asynchronous reset between clock edges
        @(negedge clk_1MHz);
        #2 rst = 1'b1;
        #1;
        check("async_rst_cursor", 32'(cursor), 32'h00);
        check("async_rst_errors", 32'({err_short_en, err_rw, err_addr, err_busy}), 32'h0);
        @(negedge clk_1MHz);
        rst = 1'b0;
        read_cell(5'h00, v);
        check("async_rst_cell0", 32'(v), 32'h20);

        repeat (5) @(negedge clk_1MHz);
        check("all_reports_seen", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
